arrow_scroll: RTL and testbench

ARROW_SCROLL -- requirements
Module: arrow_scroll

---
 rtl/arrow_scroll.sv | 197 +++++++++++++++++++
 tb/tb_arrow_scroll.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_scroll.sv
`default_nettype none
// ============================================================================
//  Module      : arrow_scroll
//  Description : Multi-lane falling-arrow engine. Each lane moves a box down
//                once per frame, catches timed button hits and flashes, and
//                renders the box as registered per-lane pixel flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module arrow_scroll #(
    parameter int CORDW        = 10,
    parameter int ARROW_COUNT  = 3,
    parameter int ARROWX_BEGIN = 0,
    parameter int ARROWX_STEP  = 64,
    parameter int ARROW_SIZE   = 5,
    parameter int Y_START      = 0,
    parameter int Y_TARGET     = 400,
    parameter int HIT_WIN      = 16,
    parameter int Y_LIMIT      = 479,
    parameter int SPEED        = 2,
    parameter int FLASH_FRAMES = 8,
    localparam int LW          = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         frame_i,
    input  logic [CORDW-1:0]             sx_i,
    input  logic [CORDW-1:0]             sy_i,
    input  logic                         spawn_valid_i,
    input  logic [LW-1:0]                spawn_lane_i,
    output logic                         spawn_ready_o,
    input  logic [ARROW_COUNT-1:0]       hit_i,
    output logic [ARROW_COUNT-1:0]       arrow_o,
    output logic [ARROW_COUNT-1:0]       flash_o,
    output logic [ARROW_COUNT-1:0]       hit_o,
    output logic [ARROW_COUNT-1:0]       miss_o,
    output logic [15:0]                  score_o,
    output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o
);

    localparam int CW       = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam int WIN_LO_I = (Y_TARGET > HIT_WIN) ? (Y_TARGET - HIT_WIN) : 0;

    localparam logic [CORDW-1:0] C_Y_START = CORDW'(Y_START);
    localparam logic [CORDW:0]   C_SPEED   = (CORDW+1)'(SPEED);
    localparam logic [CORDW:0]   C_Y_LIMIT = (CORDW+1)'(Y_LIMIT);
    localparam logic [CORDW:0]   C_SIZE    = (CORDW+1)'(ARROW_SIZE);
    localparam logic [CORDW:0]   C_WIN_LO  = (CORDW+1)'(WIN_LO_I);
    localparam logic [CORDW:0]   C_WIN_HI  = (CORDW+1)'(Y_TARGET + HIT_WIN);
    localparam logic [CW-1:0]    C_FLASH   = CW'(FLASH_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_FLASH = 2'd2
    } lane_state_t;

    logic [ARROW_COUNT-1:0] w_lane_idle;
    logic [ARROW_COUNT-1:0] w_spawn_sel;
    logic [ARROW_COUNT-1:0] w_hit_nxt;
    logic [ARROW_COUNT-1:0] w_miss_nxt;
    logic [ARROW_COUNT-1:0] w_arrow_nxt;
    logic [ARROW_COUNT-1:0] w_flash_nxt;
    logic                   w_spawn_fire;
    logic [3:0]             w_hit_cnt;
    logic [16:0]            w_score_sum;

    // Lane indices beyond ARROW_COUNT never match, so they read as not ready.
    always_comb begin
        spawn_ready_o = 1'b0;
        w_spawn_sel   = '0;
        for (int i = 0; i < ARROW_COUNT; i++) begin
            if (spawn_lane_i == LW'(i)) begin
                spawn_ready_o  = w_lane_idle[i];
                w_spawn_sel[i] = 1'b1;
            end
        end
    end

    assign w_spawn_fire = spawn_valid_i & spawn_ready_o;

    for (genvar n = 0; n < ARROW_COUNT; n++) begin : g_lane
        localparam logic [CORDW:0] C_X_LO = (CORDW+1)'(ARROWX_BEGIN + n*ARROWX_STEP);
        localparam logic [CORDW:0] C_X_HI = (CORDW+1)'(ARROWX_BEGIN + n*ARROWX_STEP + ARROW_SIZE);

        lane_state_t      r_state;
        lane_state_t      w_state_nxt;
        logic [CORDW-1:0] r_y;
        logic [CORDW-1:0] w_y_nxt;
        logic [CW-1:0]    r_cnt;
        logic [CW-1:0]    w_cnt_nxt;
        logic [CORDW:0]   w_y_ext;
        logic [CORDW:0]   w_y_adv;
        logic [CORDW:0]   w_sx_ext;
        logic [CORDW:0]   w_sy_ext;
        logic             w_in_win;
        logic             w_in_box;
        logic             w_hit;
        logic             w_miss;

        // One extra bit keeps y+SPEED and y+ARROW_SIZE from wrapping.
        assign w_y_ext  = {1'b0, r_y};
        assign w_y_adv  = w_y_ext + C_SPEED;
        assign w_sx_ext = {1'b0, sx_i};
        assign w_sy_ext = {1'b0, sy_i};
        assign w_in_win = (w_y_ext >= C_WIN_LO) && (w_y_ext <= C_WIN_HI);
        assign w_in_box = (w_sx_ext >= C_X_LO) && (w_sx_ext <= C_X_HI) &&
                          (w_sy_ext >= w_y_ext) && (w_sy_ext <= w_y_ext + C_SIZE);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= S_IDLE;
                r_y     <= C_Y_START;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_y     <= w_y_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // A hit outranks a same-cycle frame tick, so the box freezes in place.
        always_comb begin
            w_state_nxt = r_state;
            w_y_nxt     = r_y;
            w_cnt_nxt   = r_cnt;
            w_hit       = 1'b0;
            w_miss      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_spawn_fire && w_spawn_sel[n]) begin
                        w_state_nxt = S_MOVE;
                        w_y_nxt     = C_Y_START;
                    end
                end
                S_MOVE: begin
                    if (hit_i[n] && w_in_win) begin
                        w_state_nxt = S_FLASH;
                        w_cnt_nxt   = C_FLASH;
                        w_hit       = 1'b1;
                    end else if (frame_i) begin
                        if (w_y_adv > C_Y_LIMIT) begin
                            w_state_nxt = S_IDLE;
                            w_miss      = 1'b1;
                        end else begin
                            w_y_nxt = w_y_adv[CORDW-1:0];
                        end
                    end
                end
                S_FLASH: begin
                    if (frame_i) begin
                        if (r_cnt <= CW'(1)) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        assign w_lane_idle[n]               = (r_state == S_IDLE);
        assign w_hit_nxt[n]                 = w_hit;
        assign w_miss_nxt[n]                = w_miss;
        assign w_arrow_nxt[n]               = w_in_box && (r_state == S_MOVE);
        assign w_flash_nxt[n]               = w_in_box && (r_state == S_FLASH);
        assign arrow_y_o[n*CORDW +: CORDW]  = r_y;
    end

    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < ARROW_COUNT; i++) begin
            w_hit_cnt = w_hit_cnt + 4'(w_hit_nxt[i]);
        end
    end

    assign w_score_sum = {1'b0, score_o} + 17'(w_hit_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_o   <= '0;
            miss_o  <= '0;
            arrow_o <= '0;
            flash_o <= '0;
            score_o <= '0;
        end else begin
            hit_o   <= w_hit_nxt;
            miss_o  <= w_miss_nxt;
            arrow_o <= w_arrow_nxt;
            flash_o <= w_flash_nxt;
            score_o <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arrow_scroll.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arrow_scroll
//  Description : Directed self-checking bench for arrow_scroll (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arrow_scroll;

    localparam int CORDW = 10;
    localparam int N     = 3;

    typedef struct packed {
        logic [N-1:0] hit;
        logic [N-1:0] miss;
    } ev_t;

    logic                 clk         = 1'b0;
    logic                 rst_n       = 1'b0;
    logic                 frame       = 1'b0;
    logic                 spawn_valid = 1'b0;
    logic [1:0]           spawn_lane  = 2'd0;
    logic [CORDW-1:0]     sx          = '0;
    logic [CORDW-1:0]     sy          = '0;
    logic [N-1:0]         hit_in      = '0;
    logic                 spawn_ready;
    logic [N-1:0]         arrow;
    logic [N-1:0]         flash;
    logic [N-1:0]         hit_out;
    logic [N-1:0]         miss_out;
    logic [15:0]          score;
    logic [CORDW*N-1:0]   arrow_y;

    int   checks = 0;
    int   errors = 0;
    ev_t  ev_q[$];
    ev_t  ev_exp;
    logic pix_q[$];
    logic pix_exp;

    arrow_scroll dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_i       (frame),
        .sx_i          (sx),
        .sy_i          (sy),
        .spawn_valid_i (spawn_valid),
        .spawn_lane_i  (spawn_lane),
        .spawn_ready_o (spawn_ready),
        .hit_i         (hit_in),
        .arrow_o       (arrow),
        .flash_o       (flash),
        .hit_o         (hit_out),
        .miss_o        (miss_out),
        .score_o       (score),
        .arrow_y_o     (arrow_y)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frames(input int k);
        repeat (k) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            tick();
        end
    endtask

    task automatic spawn(input logic [1:0] lane);
        spawn_lane  = lane;
        spawn_valid = 1'b1;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [CORDW-1:0] ylane(input int n);
        return arrow_y[n*CORDW +: CORDW];
    endfunction

    // Every hit/miss pulse must match the next queued expectation, once.
    always @(negedge clk) begin
        if (rst_n && ((hit_out | miss_out) != '0)) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $error("FAIL event_unexpected observed hit=%b miss=%b expected none",
                       hit_out, miss_out);
            end else begin
                ev_exp = ev_q.pop_front();
                assert ({hit_out, miss_out} === ev_exp) else begin
                    errors++;
                    $error("FAIL event observed=%b expected=%b", {hit_out, miss_out}, ev_exp);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_arrow", 32'(arrow), 0);
        chk("rst_flash", 32'(flash), 0);
        chk("rst_hit", 32'(hit_out), 0);
        chk("rst_miss", 32'(miss_out), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_y", 32'(arrow_y), 0);
        chk("rst_ready_lane0", 32'(spawn_ready), 1);
        spawn_lane = 2'd3;
        #1;
        chk("ready_lane3", 32'(spawn_ready), 0);
        rst_n = 1'b1;
        tick();

        // Spawn lane 1 together with a frame tick: starts at Y_START
        spawn_lane  = 2'd1;
        spawn_valid = 1'b1;
        frame       = 1'b1;
        tick();
        spawn_valid = 1'b0;
        frame       = 1'b0;
        chk("spawn_frame_y1", 32'(ylane(1)), 0);
        chk("ready_busy_lane1", 32'(spawn_ready), 0);
        do_frames(10);
        chk("y1_after10", 32'(ylane(1)), 20);
        do_frames(229);
        chk("y1_at478", 32'(ylane(1)), 478);
        ev_q.push_back(ev_t'({3'b000, 3'b010}));
        do_frames(1);
        chk("miss_consumed", 32'(ev_q.size()), 0);
        chk("ready_lane1_idle", 32'(spawn_ready), 1);

        // Spawn onto a busy lane and onto a nonexistent lane
        spawn(2'd2);
        do_frames(3);
        chk("y2_after3", 32'(ylane(2)), 6);
        spawn_lane  = 2'd2;
        spawn_valid = 1'b1;
        #1;
        chk("ready_busy_lane2", 32'(spawn_ready), 0);
        tick();
        spawn_valid = 1'b0;
        chk("y2_unchanged", 32'(ylane(2)), 6);
        spawn_lane  = 2'd3;
        spawn_valid = 1'b1;
        #1;
        chk("ready_lane3_run", 32'(spawn_ready), 0);
        tick();
        spawn_valid = 1'b0;
        spawn_lane  = 2'd0;
        #1;
        chk("lane0_still_idle", 32'(spawn_ready), 1);
        do_reset();
        chk("rst_mid_move_y2", 32'(ylane(2)), 0);
        spawn_lane = 2'd2;
        #1;
        chk("rst_mid_move_ready2", 32'(spawn_ready), 1);

        // Hit window: y=382 ignored, y=384 accepted
        spawn(2'd0);
        do_frames(191);
        chk("y0_at382", 32'(ylane(0)), 382);
        hit_in = 3'b001;
        tick();
        hit_in = 3'b000;
        tick();
        chk("early_hit_score", 32'(score), 0);
        chk("early_hit_y0", 32'(ylane(0)), 382);
        chk("early_hit_busy", 32'(spawn_ready), 0);
        do_frames(1);
        chk("y0_at384", 32'(ylane(0)), 384);
        ev_q.push_back(ev_t'({3'b001, 3'b000}));
        hit_in = 3'b001;
        tick();
        hit_in = 3'b000;
        chk("hit_pulse", 32'(hit_out), 1);
        tick();
        chk("hit_score", 32'(score), 1);
        sx = 10'd2;
        sy = 10'd386;
        tick();
        tick();
        chk("flash_on", 32'(flash), 1);
        chk("arrow_off_in_flash", 32'(arrow), 0);
        hit_in = 3'b001;
        tick();
        hit_in = 3'b000;
        tick();
        chk("flash_hit_ignored", 32'(score), 1);
        do_frames(7);
        chk("flash_after7", 32'(flash), 1);
        chk("flash_y_frozen", 32'(ylane(0)), 384);
        do_frames(1);
        tick();
        chk("flash_done", 32'(flash), 0);
        spawn_lane = 2'd0;
        #1;
        chk("flash_done_idle", 32'(spawn_ready), 1);

        // Hit and frame together at y=416, then reset during flash
        do_reset();
        spawn(2'd0);
        do_frames(208);
        chk("y0_at416", 32'(ylane(0)), 416);
        ev_q.push_back(ev_t'({3'b001, 3'b000}));
        hit_in = 3'b001;
        frame  = 1'b1;
        tick();
        hit_in = 3'b000;
        frame  = 1'b0;
        tick();
        chk("hit_frame_y", 32'(ylane(0)), 416);
        chk("hit_frame_score", 32'(score), 1);
        sx = 10'd0;
        sy = 10'd420;
        tick();
        tick();
        chk("flash_before_rst", 32'(flash), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flash", 32'(flash), 0);
        chk("async_rst_score", 32'(score), 0);
        chk("async_rst_y", 32'(arrow_y), 0);
        chk("async_rst_pulses", 32'({hit_out, miss_out}), 0);
        chk("async_rst_ready", 32'(spawn_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Raster over lane 0 at y=100; output compared one pixel late
        spawn(2'd0);
        do_frames(50);
        chk("y0_at100", 32'(ylane(0)), 100);
        for (int py = 97; py <= 107; py++) begin
            for (int px = 0; px <= 8; px++) begin
                sx = 10'(px);
                sy = 10'(py);
                pix_q.push_back((px <= 5) && (py >= 100) && (py <= 105));
                #1;
                if (pix_q.size() > 1) begin
                    pix_exp = pix_q.pop_front();
                    chk("raster_arrow0", 32'(arrow[0]), 32'(pix_exp));
                end
                tick();
            end
        end
        for (int px = 62; px <= 66; px++) begin
            sx = 10'(px);
            sy = 10'd100;
            pix_q.push_back(1'b0);
            #1;
            pix_exp = pix_q.pop_front();
            chk("raster_arrow0", 32'(arrow[0]), 32'(pix_exp));
            tick();
        end
        #1;
        pix_exp = pix_q.pop_front();
        chk("raster_arrow0_last", 32'(arrow[0]), 32'(pix_exp));
        chk("raster_lane1_off", 32'(arrow[1]), 0);
        chk("raster_flash_off", 32'(flash), 0);

        tick();
        chk("events_drained", 32'(ev_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
